// File: rtl/univ_shift_reg.sv
// Universal shift register: load, bidirectional/arithmetic shift, rotate and clear,
// with a saturating shift counter and a one-cycle done pulse for SERDES use.
module univ_shift_reg #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;
  logic [WIDTH-1:0] next_q_s;
  logic             shift_s;
  logic             cnt_clr_s;
  logic             cnt_sat_s;

  assign cnt_sat_s = (cnt_r == CNT_MAX);

  // Next register value and operation class for the selected mode
  always_comb begin
    next_q_s  = q_r;
    shift_s   = 1'b0;
    cnt_clr_s = 1'b0;
    case (mode)
      3'b000: begin
        next_q_s = q_r;
      end
      3'b001: begin
        next_q_s = {q_r[WIDTH-2:0], sin_l};
        shift_s  = 1'b1;
      end
      3'b010: begin
        next_q_s = {sin_r, q_r[WIDTH-1:1]};
        shift_s  = 1'b1;
      end
      3'b011: begin
        next_q_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        shift_s  = 1'b1;
      end
      3'b100: begin
        next_q_s = {q_r[0], q_r[WIDTH-1:1]};
        shift_s  = 1'b1;
      end
      3'b101: begin
        next_q_s  = d;
        cnt_clr_s = 1'b1;
      end
      3'b110: begin
        next_q_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        shift_s  = 1'b1;
      end
      3'b111: begin
        next_q_s  = {WIDTH{1'b0}};
        cnt_clr_s = 1'b1;
      end
      default: begin
        next_q_s  = q_r;
        shift_s   = 1'b0;
        cnt_clr_s = 1'b0;
      end
    endcase
  end

  // Register, counter and done-pulse state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= {WIDTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
      done_r <= 1'b0;
    end else if (en) begin
      q_r    <= next_q_s;
      done_r <= shift_s && (cnt_r == CNT_LAST);
      if (cnt_clr_s) begin
        cnt_r <= {CW{1'b0}};
      end else if (shift_s && !cnt_sat_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign q      = q_r;
  assign cnt    = cnt_r;
  assign done   = done_r;
  assign sout_l = q_r[WIDTH-1];
  assign sout_r = q_r[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed table-driven bench for univ_shift_reg at WIDTH=4, plus an
// asynchronous mid-cycle reset sequence.
module tb_univ_shift_reg;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    cnt;
  logic             done;

  int n_vec;
  int n_err;

  typedef struct {
    string            name;
    logic             en;
    logic [2:0]       mode;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] exp_q;
    logic [CW-1:0]    exp_cnt;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_l(sin_l), .sin_r(sin_r),
    .d(d), .q(q), .sout_l(sout_l), .sout_r(sout_r), .cnt(cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] eq,
                       input logic [CW-1:0] ec, input logic ed);
    logic [WIDTH-1:0] eqv;
    eqv = eq;
    n_vec++;
    if (q !== eq || cnt !== ec || done !== ed || sout_l !== eqv[WIDTH-1] || sout_r !== eqv[0]) begin
      n_err++;
      $display("FAIL %s: got q=%b cnt=%0d done=%b sout_l=%b sout_r=%b, want q=%b cnt=%0d done=%b sout_l=%b sout_r=%b",
               name, q, cnt, done, sout_l, sout_r, eq, ec, ed, eqv[WIDTH-1], eqv[0]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    en = v.en; mode = v.mode; sin_l = v.sin_l; sin_r = v.sin_r; d = v.d;
    @(posedge clk);
    #1;
    check(v.name, v.exp_q, v.exp_cnt, v.exp_done);
  endtask

  task automatic add(input string nm, input logic e, input logic [2:0] m,
                     input logic sl, input logic sr, input logic [WIDTH-1:0] dd,
                     input logic [WIDTH-1:0] eq, input logic [CW-1:0] ec, input logic ed);
    vec_t v;
    v.name = nm; v.en = e; v.mode = m; v.sin_l = sl; v.sin_r = sr; v.d = dd;
    v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; en = 1'b0; mode = 3'b000; sin_l = 1'b0; sin_r = 1'b0; d = 4'b0000;

    // Table: name, en, mode, sin_l, sin_r, d, exp q, exp cnt, exp done
    add("sl_load",  1'b1, 3'b101, 1'b0, 1'b0, 4'b1011, 4'b1011, 3'd0, 1'b0);
    add("sl_1",     1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0110, 3'd1, 1'b0);
    add("sl_2",     1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b1100, 3'd2, 1'b0);
    add("sl_3",     1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b1000, 3'd3, 1'b0);
    add("sl_4",     1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b1);
    add("sl_hold",  1'b1, 3'b000, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd4, 1'b0);
    add("rr_load",  1'b1, 3'b101, 1'b0, 1'b0, 4'b1011, 4'b1011, 3'd0, 1'b0);
    add("rr_1",     1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b1101, 3'd1, 1'b0);
    add("rr_2",     1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b1110, 3'd2, 1'b0);
    add("rr_3",     1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b0111, 3'd3, 1'b0);
    add("rr_4",     1'b1, 3'b100, 1'b0, 1'b0, 4'b0000, 4'b1011, 3'd4, 1'b1);
    add("ar_load",  1'b1, 3'b101, 1'b0, 1'b0, 4'b1000, 4'b1000, 3'd0, 1'b0);
    add("asr_1",    1'b1, 3'b110, 1'b0, 1'b1, 4'b0000, 4'b1100, 3'd1, 1'b0);
    add("asr_2",    1'b1, 3'b110, 1'b0, 1'b1, 4'b0000, 4'b1110, 3'd2, 1'b0);
    add("asr_3",    1'b1, 3'b110, 1'b0, 1'b1, 4'b0000, 4'b1111, 3'd3, 1'b0);
    add("lsr_0",    1'b1, 3'b010, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd4, 1'b1);
    add("lsr_1",    1'b1, 3'b010, 1'b0, 1'b1, 4'b0000, 4'b1011, 3'd4, 1'b0);
    add("en_load",  1'b1, 3'b101, 1'b0, 1'b0, 4'b0101, 4'b0101, 3'd0, 1'b0);
    add("en_off_1", 1'b0, 3'b001, 1'b1, 1'b1, 4'b1111, 4'b0101, 3'd0, 1'b0);
    add("en_off_2", 1'b0, 3'b001, 1'b1, 1'b1, 4'b1111, 4'b0101, 3'd0, 1'b0);
    add("en_off_3", 1'b0, 3'b111, 1'b1, 1'b1, 4'b1111, 4'b0101, 3'd0, 1'b0);
    add("rl_1",     1'b1, 3'b011, 1'b0, 1'b0, 4'b0000, 4'b1010, 3'd1, 1'b0);
    add("hold_mid", 1'b1, 3'b000, 1'b1, 1'b1, 4'b1111, 4'b1010, 3'd1, 1'b0);
    add("sat_load", 1'b1, 3'b101, 1'b0, 1'b0, 4'b0001, 4'b0001, 3'd0, 1'b0);
    add("sat_1",    1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0011, 3'd1, 1'b0);
    add("sat_2",    1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd2, 1'b0);
    add("sat_3",    1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd3, 1'b0);
    add("sat_4",    1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b1);
    add("sat_5",    1'b1, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b1110, 3'd4, 1'b0);
    add("sat_6",    1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1101, 3'd4, 1'b0);
    add("clr",      1'b1, 3'b111, 1'b1, 1'b1, 4'b1111, 4'b0000, 3'd0, 1'b0);
    add("re_1",     1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0001, 3'd1, 1'b0);
    add("re_2",     1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0011, 3'd2, 1'b0);
    add("re_3",     1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b0111, 3'd3, 1'b0);
    add("re_4",     1'b1, 3'b001, 1'b1, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b1);
    add("re_en_off",1'b0, 3'b001, 1'b0, 1'b0, 4'b0000, 4'b1111, 3'd4, 1'b0);
    add("re_load",  1'b1, 3'b101, 1'b0, 1'b0, 4'b1001, 4'b1001, 3'd0, 1'b0);

    // Power-on reset, then reach q=1011, cnt=2 for the mid-cycle reset
    #3;
    check("por", 4'b0000, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v.name = "pre_load"; v.en = 1'b1; v.mode = 3'b101; v.sin_l = 1'b0; v.sin_r = 1'b0;
      v.d = 4'b1110; v.exp_q = 4'b1110; v.exp_cnt = 3'd0; v.exp_done = 1'b0;
      apply(v);
      v.name = "pre_rl1"; v.mode = 3'b011; v.exp_q = 4'b1101; v.exp_cnt = 3'd1;
      apply(v);
      v.name = "pre_rl2"; v.exp_q = 4'b1011; v.exp_cnt = 3'd2;
      apply(v);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", 4'b0000, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held", 4'b0000, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; mode = 3'b000;
    @(posedge clk);
    #1;
    check("rst_hold", 4'b0000, 3'd0, 1'b0);

    foreach (vecs[i]) apply(vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got still running, want finished");
    $fatal(1, "timeout");
  end

endmodule
